// File: rtl/tamaguchi_pkg.sv
// Shared encodings and status-field layout for the pet display path.
package tamaguchi_pkg;
  localparam int LEVEL_W  = 3;
  localparam int SPRITE_W = 3;

  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    IDLE     = 2'd1,
    DRAW     = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [LEVEL_W-1:0]  hambre;
    logic [LEVEL_W-1:0]  diversion;
    logic [LEVEL_W-1:0]  energia;
    logic                salud;
    logic [SPRITE_W-1:0] state;
    logic                modo;
  } pet_status_t;
endpackage

// File: rtl/tick_gen.sv
// Generic free-running prescaler: one-cycle tick each PERIOD enabled cycles.
module tick_gen #(
  parameter int PERIOD = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  assign tick = en & (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/display_refresh_scheduler.sv
// Frame scheduler: freezes a pet-status snapshot per frame and pulses frame_start
// when the status or the animation phase needs a redraw.
module display_refresh_scheduler
  import tamaguchi_pkg::*;
#(
  parameter int ANIM_PERIOD = 25_000_000,
  parameter int MIN_GAP     = 1_000_000,
  parameter int TIMEOUT     = 4_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                disp_ready,
  input  logic                frame_done,
  input  logic [LEVEL_W-1:0]  hambre_i,
  input  logic [LEVEL_W-1:0]  diversion_i,
  input  logic [LEVEL_W-1:0]  energia_i,
  input  logic                salud_i,
  input  logic [SPRITE_W-1:0] state_i,
  input  logic                modo_i,
  output logic                frame_start,
  output logic [LEVEL_W-1:0]  hambre_o,
  output logic [LEVEL_W-1:0]  diversion_o,
  output logic [LEVEL_W-1:0]  energia_o,
  output logic                salud_o,
  output logic [SPRITE_W-1:0] state_o,
  output logic                modo_o,
  output logic                anim_phase,
  output logic                busy,
  output logic                timeout_err,
  output logic [7:0]          anim_miss
);
  localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  sched_state_t     state, state_nx;
  pet_status_t      live, snap;
  logic [GAP_W-1:0] gap;
  logic [TMO_W-1:0] tmo;
  logic             anim_req, tick, dirty, launch, done_ev, to_ev;

  tick_gen #(.PERIOD(ANIM_PERIOD)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .tick (tick)
  );

  assign live    = {hambre_i, diversion_i, energia_i, salud_i, state_i, modo_i};
  assign dirty   = (live != snap) | anim_req;
  assign launch  = (state == IDLE) & disp_ready & dirty & (gap == '0);
  assign done_ev = (state == DRAW) & frame_done;
  assign to_ev   = (state == DRAW) & ~frame_done & (tmo == TMO_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      WAIT_RDY: if (disp_ready) state_nx = IDLE;
      IDLE:     if (!disp_ready) state_nx = WAIT_RDY;
                else if (launch) state_nx = DRAW;
      DRAW:     if (!disp_ready) state_nx = WAIT_RDY;
                else if (done_ev | to_ev) state_nx = IDLE;
      default:  state_nx = WAIT_RDY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= WAIT_RDY;
      snap        <= '0;
      gap         <= '0;
      tmo         <= '0;
      anim_req    <= 1'b0;
      anim_phase  <= 1'b0;
      anim_miss   <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      frame_start <= launch;
      busy        <= (state_nx == DRAW);
      if (to_ev) timeout_err <= 1'b1;

      if (done_ev | to_ev)  gap <= GAP_W'(MIN_GAP);
      else if (gap != '0)   gap <= gap - GAP_W'(1);

      tmo <= (state == DRAW) ? tmo + TMO_W'(1) : '0;

      if (launch) begin
        snap <= live;
        if (anim_req) anim_phase <= ~anim_phase;
      end

      // A tick landing on the launch edge re-arms the request rather than being lost.
      if (tick)        anim_req <= 1'b1;
      else if (launch) anim_req <= 1'b0;

      if (tick & anim_req & ~launch & (anim_miss != 8'hFF))
        anim_miss <= anim_miss + 8'd1;
    end
  end

  assign hambre_o    = snap.hambre;
  assign diversion_o = snap.diversion;
  assign energia_o   = snap.energia;
  assign salud_o     = snap.salud;
  assign state_o     = snap.state;
  assign modo_o      = snap.modo;
endmodule

// File: tb/tb_display_refresh_scheduler.sv
// Directed bench: stimulus pushes the expected snapshot of each frame; a monitor
// pops and compares on every frame_start.
module tb_display_refresh_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       disp_ready = 1'b0, frame_done = 1'b0;
  logic [2:0] hambre_i = '0, diversion_i = '0, energia_i = '0, state_i = '0;
  logic       salud_i = 1'b0, modo_i = 1'b0;
  logic       frame_start, salud_o, modo_o, anim_phase, busy, timeout_err;
  logic [2:0] hambre_o, diversion_o, energia_o, state_o;
  logic [7:0] anim_miss;

  int n_tests = 0;
  int n_fail  = 0;
  logic [14:0] exp_q[$];

  display_refresh_scheduler #(.ANIM_PERIOD(100), .MIN_GAP(10), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .disp_ready(disp_ready), .frame_done(frame_done),
    .hambre_i(hambre_i), .diversion_i(diversion_i), .energia_i(energia_i),
    .salud_i(salud_i), .state_i(state_i), .modo_i(modo_i),
    .frame_start(frame_start), .hambre_o(hambre_o), .diversion_o(diversion_o),
    .energia_o(energia_o), .salud_o(salud_o), .state_o(state_o), .modo_o(modo_o),
    .anim_phase(anim_phase), .busy(busy), .timeout_err(timeout_err),
    .anim_miss(anim_miss)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int h, input int d, input int e, input int s,
                      input int st, input int m, input int ph);
    exp_q.push_back({3'(h), 3'(d), 3'(e), 1'(s), 3'(st), 1'(m), 1'(ph)});
  endtask

  // Negedges until frame_start is seen; -1 reported if the bound expires.
  task automatic wait_frame(input string name, input int exp_cyc, input int bound);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!frame_start && cyc < bound);
    chk(name, frame_start ? cyc : -1, exp_cyc);
  endtask

  always @(negedge clk) begin
    if (rst && frame_start) begin
      logic [14:0] act, e;
      act = {hambre_o, diversion_o, energia_o, salud_o, state_o, modo_o, anim_phase};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_frame: got snapshot %h, expected no frame_start", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL frame_snapshot: got %h, expected %h", act, e);
        end
      end
    end
  end

  initial begin
    nclk(3);
    chk("reset_outputs", int'({frame_start, hambre_o, diversion_o, energia_o, salud_o,
        state_o, modo_o, anim_phase, busy, timeout_err, anim_miss}), 0);
    rst = 1'b1;
    disp_ready = 1'b1;

    // 1: first status change draws one cycle later
    nclk(2);
    hambre_i = 3'd3; energia_i = 3'd1;
    push(3, 0, 1, 0, 0, 0, 0);
    wait_frame("t1_latency", 1, 20);
    chk("t1_busy", int'(busy), 1);
    nclk(1);
    chk("t1_pulse_width", int'(frame_start), 0);

    // 2: changes during DRAW coalesce into one frame after the gap (10 + 1 launch cycle)
    energia_i = 3'd2;
    nclk(1);
    energia_i = 3'd4;
    nclk(1);
    chk("t2_busy_in_draw", int'(busy), 1);
    frame_done = 1'b1;
    nclk(1);
    frame_done = 1'b0;
    chk("t2_busy_after_done", int'(busy), 0);
    push(3, 0, 4, 0, 0, 0, 0);
    wait_frame("t2_gap_latency", 11, 40);
    nclk(2);
    frame_done = 1'b1;
    nclk(1);
    frame_done = 1'b0;

    // 3: animation tick alone triggers a frame and flips the phase
    push(3, 0, 4, 0, 0, 0, 1);
    wait_frame("t3_tick_latency", 80, 200);
    chk("t3_miss_zero", int'(anim_miss), 0);
    nclk(2);
    frame_done = 1'b1;
    nclk(1);
    frame_done = 1'b0;
    disp_ready = 1'b0;
    nclk(316);
    chk("t3_anim_miss", int'(anim_miss), 2);
    chk("t3_busy_wait", int'(busy), 0);

    // 5b: pending animation request draws once the display is ready again
    disp_ready = 1'b1;
    push(3, 0, 4, 0, 0, 0, 0);
    wait_frame("t5_ready_latency", 2, 20);

    // 4: no frame_done -> timeout after 50 DRAW cycles
    nclk(49);
    chk("t4_busy_before_to", int'(busy), 1);
    chk("t4_err_before_to", int'(timeout_err), 0);
    nclk(1);
    chk("t4_busy_after_to", int'(busy), 0);
    chk("t4_err_after_to", int'(timeout_err), 1);
    salud_i = 1'b1; diversion_i = 3'd2; state_i = 3'd5;
    push(3, 2, 4, 1, 5, 0, 0);
    wait_frame("t4_gap_latency", 11, 40);

    // 5a: dropping disp_ready aborts DRAW without a new frame
    nclk(2);
    disp_ready = 1'b0;
    nclk(1);
    chk("t5_busy_drop", int'(busy), 0);
    chk("t5_no_start", int'(frame_start), 0);
    modo_i = 1'b1;
    nclk(3);
    disp_ready = 1'b1;
    push(3, 2, 4, 1, 5, 1, 0);
    wait_frame("t5_dirty_latency", 2, 20);

    // 6: async reset mid-DRAW, then stray frame_done pulses
    nclk(2);
    #2;
    rst = 1'b0;
    disp_ready = 1'b0;
    #1;
    chk("t6_async_reset", int'({frame_start, hambre_o, diversion_o, energia_o, salud_o,
        state_o, modo_o, anim_phase, busy, timeout_err, anim_miss}), 0);
    @(negedge clk);
    rst = 1'b1;
    nclk(1);
    frame_done = 1'b1;
    nclk(1);
    frame_done = 1'b0;
    nclk(1);
    frame_done = 1'b1;
    nclk(1);
    frame_done = 1'b0;
    nclk(1);
    chk("t6_idle_outputs", int'({busy, timeout_err, frame_start}), 0);
    disp_ready = 1'b1;
    push(3, 2, 4, 1, 5, 1, 0);
    wait_frame("t6_post_reset_latency", 2, 20);
    nclk(1);
    frame_done = 1'b1;
    nclk(1);
    frame_done = 1'b0;
    nclk(3);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
